// File: rtl/cpu0_jtag_debug_host_if.sv
// Command/response handshake and virtual-JTAG pins of the debug scan host.
// slave is the host-block view; master is the view of whoever drives commands and the target.
interface cpu0_jtag_debug_host_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;
  logic                vji_rti;

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo,
    output cmd_ready, rsp_valid, rsp_data,
    output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_data,
    input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );
endinterface

// File: rtl/cpu0_jtag_debug_host.sv
// Virtual-JTAG scan master: turns one IR/DR command into a UIR-CDR-SDR-UDR-RTI
// sequence for the Nios II debug module and returns the captured tdo word.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// UIR    | one tck period, virtual update-IR with new ir_in
// CDR    | one tck period, target captures its DR
// SDR    | SR_WIDTH tck periods, tdi out / tdo in, LSB first
// UDR    | one tck period, target updates its DR
// RTI    | RTI_CYCLES tck periods of run-test/idle
// RESP   | rsp_valid high with captured word until rsp_ready
module cpu0_jtag_debug_host #(
  parameter int SR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu0_jtag_debug_host_if.slave io_dbg
);

  localparam int DIV_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int SHIFT_W = $clog2(SR_WIDTH + 1);
  localparam int RTI_W   = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LOAD   = DIV_W'(TCK_DIV - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LOAD = SHIFT_W'(SR_WIDTH - 1);
  localparam logic [RTI_W-1:0]   RTI_LOAD   = RTI_W'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic                r_tck;
  logic                r_tdi;
  logic                r_uir;
  logic                r_cdr;
  logic                r_sdr;
  logic                r_udr;
  logic                r_rti;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic [SR_WIDTH-1:0] r_tx;
  logic [SR_WIDTH-1:0] r_cap;
  logic [DIV_W-1:0]    r_div;
  logic [SHIFT_W-1:0]  r_shift_cnt;
  logic [RTI_W-1:0]    r_rti_cnt;

  logic                w_accept;
  logic                w_active;
  logic                w_tck_rise;
  logic                w_period_end;
  logic [SR_WIDTH-1:0] w_tx_next;

  assign w_accept     = io_dbg.cmd_valid && r_cmd_ready;
  assign w_active     = (r_state == S_UIR) || (r_state == S_CDR) || (r_state == S_SDR) ||
                        (r_state == S_UDR) || (r_state == S_RTI);
  assign w_tck_rise   = w_active && (r_div == '0) && !r_tck;
  // Falling edge of tck closes a period; all state changes happen here.
  assign w_period_end = w_active && (r_div == '0) && r_tck;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_tx_next    = r_tx;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_UIR;
      S_UIR:  if (w_period_end) w_next_state = S_CDR;
      S_CDR:  if (w_period_end) w_next_state = S_SDR;
      S_SDR: begin
        if (w_period_end) begin
          w_tx_next = r_tx >> 1;
          if (r_shift_cnt == '0) w_next_state = S_UDR;
        end
      end
      S_UDR:  if (w_period_end) w_next_state = S_RTI;
      S_RTI:  if (w_period_end && (r_rti_cnt == '0)) w_next_state = S_RESP;
      S_RESP: if (r_rsp_valid && io_dbg.rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_tck       <= 1'b0;
      r_tdi       <= 1'b0;
      r_uir       <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_rti       <= 1'b0;
      r_ir_in     <= '0;
      r_tx        <= '0;
      r_cap       <= '0;
      r_div       <= DIV_LOAD;
      r_shift_cnt <= '0;
      r_rti_cnt   <= '0;
    end else begin
      // Outputs decode the upcoming state so they stay registered yet change with it.
      r_cmd_ready <= (w_next_state == S_IDLE);
      r_rsp_valid <= (w_next_state == S_RESP);
      r_uir       <= (w_next_state == S_UIR);
      r_cdr       <= (w_next_state == S_CDR);
      r_sdr       <= (w_next_state == S_SDR);
      r_udr       <= (w_next_state == S_UDR);
      r_rti       <= (w_next_state == S_RTI);
      r_tdi       <= (w_next_state == S_SDR) ? w_tx_next[0] : 1'b0;
      r_tx        <= w_tx_next;

      if (w_active) begin
        if (r_div == '0) begin
          r_tck <= ~r_tck;
          r_div <= DIV_LOAD;
        end else begin
          r_div <= r_div - DIV_W'(1);
        end
      end else begin
        r_tck <= 1'b0;
        r_div <= DIV_LOAD;
      end

      if (w_tck_rise && (r_state == S_SDR)) begin
        r_cap <= {io_dbg.vji_tdo, r_cap[SR_WIDTH-1:1]};
      end

      if ((r_state == S_CDR) && w_period_end) begin
        r_shift_cnt <= SHIFT_LOAD;
      end else if ((r_state == S_SDR) && w_period_end) begin
        r_shift_cnt <= r_shift_cnt - SHIFT_W'(1);
      end

      if ((r_state == S_UDR) && w_period_end) begin
        r_rti_cnt <= RTI_LOAD;
      end else if ((r_state == S_RTI) && w_period_end) begin
        r_rti_cnt <= r_rti_cnt - RTI_W'(1);
      end

      if (w_accept) begin
        r_ir_in <= io_dbg.cmd_ir;
        r_tx    <= io_dbg.cmd_data;
        r_cap   <= '0;
      end
    end
  end

  assign io_dbg.cmd_ready = r_cmd_ready;
  assign io_dbg.rsp_valid = r_rsp_valid;
  assign io_dbg.rsp_data  = r_cap;
  assign io_dbg.vji_tck   = r_tck;
  assign io_dbg.vji_tdi   = r_tdi;
  assign io_dbg.vji_ir_in = r_ir_in;
  assign io_dbg.vji_uir   = r_uir;
  assign io_dbg.vji_cdr   = r_cdr;
  assign io_dbg.vji_sdr   = r_sdr;
  assign io_dbg.vji_udr   = r_udr;
  assign io_dbg.vji_rti   = r_rti;

endmodule

// File: tb/tb_cpu0_jtag_debug_host.sv
// Directed bench for the virtual-JTAG scan host: a default-parameter instance
// and a fast instance (TCK_DIV=1, RTI_CYCLES=1), each with a small target DR model.
module tb_cpu0_jtag_debug_host;
  localparam int SRW = 38;
  localparam int IRW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cpu0_jtag_debug_host_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) bus0();
  cpu0_jtag_debug_host_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) bus1();

  cpu0_jtag_debug_host #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(2), .RTI_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .io_dbg(bus0));
  cpu0_jtag_debug_host #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(1), .RTI_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .io_dbg(bus1));

  // Target DR models: capture at CDR, shift on tck rise in SDR, tdo = sr[0].
  logic [SRW-1:0] t0_sr = '0, t0_cap_val = '0, t0_sr_udr = '0;
  logic [IRW-1:0] t0_ir_seen = '0;
  logic [SRW-1:0] t1_sr = '0, t1_cap_val = '0, t1_sr_udr = '0;
  logic [IRW-1:0] t1_ir_seen = '0;

  always @(posedge bus0.vji_tck) begin
    if (bus0.vji_uir) t0_ir_seen <= bus0.vji_ir_in;
    if (bus0.vji_cdr) t0_sr <= t0_cap_val;
    else if (bus0.vji_sdr) t0_sr <= {bus0.vji_tdi, t0_sr[SRW-1:1]};
    if (bus0.vji_udr) t0_sr_udr <= t0_sr;
  end
  assign bus0.vji_tdo = t0_sr[0];

  always @(posedge bus1.vji_tck) begin
    if (bus1.vji_uir) t1_ir_seen <= bus1.vji_ir_in;
    if (bus1.vji_cdr) t1_sr <= t1_cap_val;
    else if (bus1.vji_sdr) t1_sr <= {bus1.vji_tdi, t1_sr[SRW-1:1]};
    if (bus1.vji_udr) t1_sr_udr <= t1_sr;
  end
  assign bus1.vji_tdo = t1_sr[0];

  // Strobe accounting, sampled mid-cycle.
  int   n_rise = 0, n_sdr_rise = 0, n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0, n_ovl = 0;
  int   n1_rise = 0;
  logic tck0_q = 1'b0, tck1_q = 1'b0;

  always @(negedge clk) begin
    if (bus0.vji_tck && !tck0_q) begin
      n_rise++;
      if (bus0.vji_sdr) n_sdr_rise++;
    end
    tck0_q = bus0.vji_tck;
    if (bus0.vji_uir) n_uir++;
    if (bus0.vji_cdr) n_cdr++;
    if (bus0.vji_sdr) n_sdr++;
    if (bus0.vji_udr) n_udr++;
    if (bus0.vji_rti) n_rti++;
    if ($countones({bus0.vji_uir, bus0.vji_cdr, bus0.vji_sdr, bus0.vji_udr, bus0.vji_rti}) > 1) n_ovl++;
    if (bus1.vji_tck && !tck1_q) n1_rise++;
    tck1_q = bus1.vji_tck;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs0();
    return 64'({bus0.cmd_ready, bus0.rsp_valid, |bus0.rsp_data, bus0.vji_tck, bus0.vji_tdi,
                bus0.vji_ir_in, bus0.vji_uir, bus0.vji_cdr, bus0.vji_sdr, bus0.vji_udr, bus0.vji_rti});
  endfunction

  // Called at a negedge with cmd_ready high; returns at the negedge rsp_valid is seen.
  task automatic run_cmd0(input logic [IRW-1:0] ir, input logic [SRW-1:0] data,
                          output int lat, output logic rdy_c1);
    bus0.cmd_ir    = ir;
    bus0.cmd_data  = data;
    bus0.cmd_valid = 1'b1;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    rdy_c1 = bus0.cmd_ready;
    lat = 1;
    while (!bus0.rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release0();
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
  endtask

  task automatic run_cmd1(input logic [IRW-1:0] ir, input logic [SRW-1:0] data,
                          output int lat, output logic [SRW-1:0] rsp);
    bus1.cmd_ir    = ir;
    bus1.cmd_data  = data;
    bus1.cmd_valid = 1'b1;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    lat = 1;
    while (!bus1.rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    rsp = bus1.rsp_data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int             lat;
    int             bad;
    int             guard;
    int             b_rise, b_sdr_rise, b_uir, b_cdr, b_sdr, b_udr, b_rti, b_ovl;
    logic           rdy;
    logic [SRW-1:0] d;

    bus0.cmd_valid = 1'b1;
    bus0.cmd_ir    = 2'b11;
    bus0.cmd_data  = '1;
    bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_ir    = 2'b11;
    bus1.cmd_data  = '1;
    bus1.rsp_ready = 1'b1;
    reset          = 1'b1;

    // Reset with cmd_valid held high
    repeat (3) @(negedge clk);
    check("rst_outputs", outs0(), 64'd0);
    reset          = 1'b0;
    bus0.cmd_valid = 1'b0;
    bus1.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready0", 64'(bus0.cmd_ready), 64'd1);
    check("rst_cmd_ready1", 64'(bus1.cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("rst_no_accept", 64'({bus0.vji_uir, bus0.vji_tck, bus0.vji_ir_in, bus0.cmd_ready}), 64'h1);

    // Single scan with defaults, plus strobe accounting
    t0_cap_val = 38'h2A5A5A5A5A;
    b_rise = n_rise; b_sdr_rise = n_sdr_rise; b_uir = n_uir; b_cdr = n_cdr;
    b_sdr = n_sdr; b_udr = n_udr; b_rti = n_rti; b_ovl = n_ovl;
    run_cmd0(2'b01, 38'h0F0F0F0F0F, lat, rdy);
    check("scan_ready_drop", 64'(rdy), 64'd0);
    check("scan_latency", 64'(lat), 64'd173);
    check("scan_rsp_data", 64'(bus0.rsp_data), 64'h2A5A5A5A5A);
    check("scan_ir_seen", 64'(t0_ir_seen), 64'h1);
    check("scan_sr_at_udr", 64'(t0_sr_udr), 64'h0F0F0F0F0F);
    check("cnt_tck_rise", 64'(n_rise - b_rise), 64'd43);
    check("cnt_uir_clk", 64'(n_uir - b_uir), 64'd4);
    check("cnt_cdr_clk", 64'(n_cdr - b_cdr), 64'd4);
    check("cnt_udr_clk", 64'(n_udr - b_udr), 64'd4);
    check("cnt_sdr_clk", 64'(n_sdr - b_sdr), 64'd152);
    check("cnt_sdr_rise", 64'(n_sdr_rise - b_sdr_rise), 64'd38);
    check("cnt_rti_clk", 64'(n_rti - b_rti), 64'd8);
    check("cnt_overlap", 64'(n_ovl - b_ovl), 64'd0);
    release0();
    check("scan_rsp_done", 64'({bus0.rsp_valid, bus0.cmd_ready}), 64'b01);

    // Response back-pressure
    t0_cap_val = 38'h1C3A5F0E21;
    run_cmd0(2'b10, 38'h2468ACE013, lat, rdy);
    check("bp_latency", 64'(lat), 64'd173);
    d = bus0.rsp_data;
    check("bp_rsp_data", 64'(d), 64'h1C3A5F0E21);
    check("bp_sr_at_udr", 64'(t0_sr_udr), 64'h2468ACE013);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== d || bus0.cmd_ready !== 1'b0 ||
          bus0.vji_tck !== 1'b0) bad++;
    end
    check("bp_hold_cycles_bad", 64'(bad), 64'd0);
    release0();
    check("bp_rsp_valid_drop", 64'(bus0.rsp_valid), 64'd0);
    check("bp_cmd_ready", 64'(bus0.cmd_ready), 64'd1);
    check("bp_ir_hold", 64'(bus0.vji_ir_in), 64'h2);

    // Reset in the middle of SDR
    t0_cap_val     = 38'h0123456789;
    b_sdr_rise     = n_sdr_rise;
    bus0.cmd_ir    = 2'b11;
    bus0.cmd_data  = 38'h155AA55AA5;
    bus0.cmd_valid = 1'b1;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    guard = 0;
    while ((n_sdr_rise - b_sdr_rise) < 20 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reach_sdr20", 64'(n_sdr_rise - b_sdr_rise), 64'd20);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", outs0(), 64'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus0.rsp_valid !== 1'b0 || bus0.vji_tck !== 1'b0) bad++;
    end
    check("mid_no_rsp_bad", 64'(bad), 64'd0);
    check("mid_cmd_ready", 64'(bus0.cmd_ready), 64'd1);
    run_cmd0(2'b01, 38'h3FFFFFFFFF, lat, rdy);
    check("mid_next_latency", 64'(lat), 64'd173);
    check("mid_next_rsp", 64'(bus0.rsp_data), 64'h0123456789);
    check("mid_next_sr_udr", 64'(t0_sr_udr), 64'h3FFFFFFFFF);
    release0();

    // Fast instance, back-to-back with rsp_ready tied high
    t1_cap_val = 38'h2BADC0FFEE;
    b_rise = n1_rise;
    run_cmd1(2'b10, 38'h0111111111, lat, d);
    check("fast_latency_a", 64'(lat), 64'd85);
    check("fast_rsp_a", 64'(d), 64'h2BADC0FFEE);
    check("fast_tck_rise_a", 64'(n1_rise - b_rise), 64'd42);
    check("fast_sr_udr_a", 64'(t1_sr_udr), 64'h0111111111);
    t1_cap_val = 38'h3000000001;
    @(negedge clk);
    check("fast_ready_b2b", 64'({bus1.cmd_ready, bus1.rsp_valid}), 64'b10);
    run_cmd1(2'b01, 38'h2AAAAAAAAA, lat, d);
    check("fast_latency_b", 64'(lat), 64'd85);
    check("fast_rsp_b", 64'(d), 64'h3000000001);
    check("fast_ir_seen_b", 64'(t1_ir_seen), 64'h1);
    check("fast_sr_udr_b", 64'(t1_sr_udr), 64'h2AAAAAAAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu0_jtag_debug_host.md
Name: cpu0_jtag_debug_host

Overview:
Host-side scan master for the Nios II debug module's virtual-JTAG interface. It accepts one IR/DR command per transaction and generates the complete virtual-JTAG sequence: UIR, CDR, SDR shift, UDR, then RTI. That sequence is the tck, tdi, ir_in and virtual-state stimulus the debug-module tck logic consumes. It captures the returned tdo stream into a response word. It is used in simulation harnesses and on-chip self-test to drive the debug module without a physical JTAG hub.

Parameters:
SR_WIDTH, 38, DR scan length in bits (matches debug-module sr width)
IR_WIDTH, 2, virtual IR width
TCK_DIV, 2, clk cycles per tck half-period; legal range >=1
RTI_CYCLES, 2, tck periods spent in RTI after UDR; legal range >=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_ir  in  IR_WIDTH  virtual IR value for this scan
cmd_data  in  SR_WIDTH  DR value shifted out, LSB first
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  SR_WIDTH  captured tdo bits; first bit captured lands in bit 0
vji_tck  out  1  generated test clock
vji_tdi  out  1  serial data to target
vji_tdo  in  1  serial data from target
vji_ir_in  out  IR_WIDTH  virtual IR to target
vji_uir  out  1  virtual update-IR state
vji_cdr  out  1  virtual capture-DR state
vji_sdr  out  1  virtual shift-DR state
vji_udr  out  1  virtual update-DR state
vji_rti  out  1  run-test/idle state

Behaviour:
- All outputs are registered.
- Reset values: every output 0; FSM in IDLE. cmd_ready is 1 in the first cycle after reset deasserts.
- FSM states: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
- tck period: TCK_DIV clk low, then TCK_DIV clk high.
- Each non-IDLE, non-RESP state lasts whole tck periods. State outputs change only at the start of the low phase (falling edge).
- vji_tck toggles only in UIR..RTI. It is held low in IDLE and RESP.
- vji_tdo is sampled on the clk cycle in which vji_tck goes 0->1.
- IDLE: cmd_ready=1.
  - On accept: latch cmd_ir into vji_ir_in and cmd_data into the tx shift register; clear the capture register.
  - cmd_ready drops the next cycle; UIR starts the next cycle.
- UIR: 1 tck period, vji_uir=1.
- CDR: 1 tck period, vji_cdr=1.
- SDR: SR_WIDTH tck periods, vji_sdr=1.
  - vji_tdi = tx[0] for the whole period; tx shifts right by one at period end.
  - At each rising edge: cap <= {vji_tdo, cap[SR_WIDTH-1:1]}.
  - Shift counter width is ceil(log2(SR_WIDTH+1)).
- UDR: 1 tck period, vji_udr=1, vji_tdi=0.
- RTI: RTI_CYCLES tck periods, vji_rti=1.
- RESP: rsp_valid=1 and rsp_data=cap, both held stable until rsp_ready.
  - On handshake: rsp_valid=0 next cycle, FSM returns to IDLE, cmd_ready=1 that same next cycle.
- vji_ir_in holds the last accepted value from UIR through IDLE. It changes only on accept.
- At most one state-strobe (uir/cdr/sdr/udr/rti) is high in any cycle.
- Latency: with accept at cycle 0, rsp_valid first asserts at cycle 1 + (3+SR_WIDTH+RTI_CYCLES)*2*TCK_DIV. With defaults this is cycle 173.
- No new command is accepted while a scan or response is pending. rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation:
  - Next cycle: all outputs 0 and FSM in IDLE. A truncated tck high phase is permitted.
  - No rsp_valid is produced for the aborted scan; the capture register is cleared.
- cmd_valid asserted during reset is ignored.

Test Plan:
1. Reset -> assert reset 3 cycles with cmd_valid=1 -> all outputs 0 during reset; cmd_ready=1 in first post-reset cycle; nothing accepted during reset.
2. Single scan, defaults:
   - Setup: bench target model captures 38'h2A5A5A5A5A at CDR; tdo=sr[0]; sr shifts on tck rise.
   - Stimulus: cmd_ir=2'b01, cmd_data=38'h0F0F0F0F0F.
   - Required: model sees ir_in=2'b01 at UIR; model sr=38'h0F0F0F0F0F at UDR; rsp_data=38'h2A5A5A5A5A; rsp_valid at cycle 173.
3. Strobe accounting -> one command, defaults:
   - 43 vji_tck rising edges.
   - vji_uir, vji_cdr, vji_udr high for exactly 4 clk each.
   - vji_sdr high for 152 clk / 38 rising edges.
   - vji_rti high for 8 clk.
   - Never two strobes high together.
4. Back-pressure -> rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid and rsp_data stable; cmd_ready=0; vji_tck=0; cmd_ready=1 the cycle after rsp_ready pulses.
5. Reset mid-SDR at 20th rising edge -> next cycle all outputs 0, no rsp_valid. Following command with cmd_data=38'h3FFFFFFFFF completes with correct capture.
6. TCK_DIV=1, RTI_CYCLES=1 -> accept at cycle 0 -> rsp_valid at cycle 1+42*2=85; vji_tck period 2 clk; back-to-back commands with rsp_ready=1 tied each produce correct rsp_data.
